// File: rtl/tcm_arb_pkg.sv
// Shared types and constants for the ITCM port arbiter.
//   owner_e     : who owns the read data returning next cycle
//   arb_state_e : arbiter session state (RUN / DRAIN / LOAD / RELEASE)
//   STARVE_LIMIT_DEF : default fetch starvation threshold (legal 1..15)
//   STARVE_CNT_W     : width of the starvation counter
package tcm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LSU,
    OWN_LDR
  } owner_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD,
    RELEASE
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

endpackage

// File: rtl/tcm_arb_starve_counter.sv
// Saturating fetch-starvation counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear to zero (wins over inc)
//   inc       : count one more denied fetch cycle
//   at_limit  : counter has reached LIMIT (fetch gets top priority)
module tcm_arb_starve_counter
  import tcm_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Holds at LIMIT instead of wrapping so fetch keeps its boost until granted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/tcm_port_arbiter.sv
// Arbiter for the single read/write port of the instruction TCM.
// Requesters: instruction fetch (read-only), load/store unit, program loader.
// One grant per cycle (combinational), read data returned one cycle later to
// the recorded owner. LSU beats fetch unless fetch has been denied
// STARVE_LIMIT cycles in a row. Loader sessions (DRAIN/LOAD/RELEASE) hold the
// core and flush fetch on release.
// Build option: define TCM_ARB_LOADER_EN to enable loader sessions; when
// undefined the arbiter stays in RUN and all loader inputs are ignored.
// Ports:
//   fetch_/lsu_/ldr_ req, we, addr, wdata : requests (held until gnt)
//   ldr_session   : loader asks for an exclusive session while high
//   *_gnt         : request accepted this cycle
//   *_rvalid,rdata: read data for the owner of last cycle's read
//   mem_*         : TCM port drive; mem_rdata valid the cycle after address
//   fetch_stall   : fetch_req & ~fetch_gnt
//   core_hold     : registered pipeline freeze during a session
//   fetch_flush   : registered one-cycle refetch pulse on session release
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic                  lsu_req,
  input  logic                  ldr_req,
  input  logic                  lsu_we,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  input  logic                  ldr_session,
  output logic                  fetch_gnt,
  output logic                  lsu_gnt,
  output logic                  ldr_gnt,
  output logic                  fetch_rvalid,
  output logic                  lsu_rvalid,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fetch_stall,
  output logic                  core_hold,
  output logic                  fetch_flush
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       session_q, session_d;
  logic       core_hold_q, core_hold_d;
  logic       fetch_flush_q, fetch_flush_d;
  logic       starve_at_limit;
  logic       starve_clr;
  logic       starve_inc;
  logic       fetch_win;

  tcm_arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (starve_clr),
    .inc      (starve_inc),
    .at_limit (starve_at_limit)
  );

  // Grants are suppressed while rst is high so the port is quiet in reset.
  always_comb begin
    fetch_gnt = 1'b0;
    lsu_gnt   = 1'b0;
    ldr_gnt   = 1'b0;
    fetch_win = fetch_req & (~lsu_req | starve_at_limit);
    if (!rst) begin
      case (state_q)
        RUN: begin
          fetch_gnt = fetch_win;
          lsu_gnt   = lsu_req & ~fetch_win;
        end
`ifdef TCM_ARB_LOADER_EN
        LOAD: ldr_gnt = ldr_req;
`endif
        default: ;
      endcase
    end
  end

  // Port mux and read ownership; writes leave no owner so no rvalid follows.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (fetch_gnt) begin
      mem_addr = fetch_addr;
      owner_d  = OWN_FETCH;
    end else if (lsu_gnt) begin
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
      owner_d   = lsu_we ? OWN_NONE : OWN_LSU;
    end
`ifdef TCM_ARB_LOADER_EN
    else if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      owner_d   = ldr_we ? OWN_NONE : OWN_LDR;
    end
`endif
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign starve_inc  = fetch_req & ~fetch_gnt;
  assign starve_clr  = fetch_gnt | (state_q == RELEASE);

  // Session entry is edge-triggered on ldr_session so a session still held
  // high after RELEASE does not immediately start another one.
  always_comb begin
    state_d = state_q;
`ifdef TCM_ARB_LOADER_EN
    session_d = ldr_session;
    case (state_q)
      RUN:     if (ldr_session && !session_q) state_d = DRAIN;
      DRAIN:   state_d = LOAD;
      LOAD:    if (!ldr_session) state_d = RELEASE;
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
`else
    session_d = 1'b0;
    state_d   = RUN;
`endif
    core_hold_d   = (state_d != RUN);
    fetch_flush_d = (state_d == RELEASE);
  end

`ifndef TCM_ARB_LOADER_EN
  logic unused_ldr;
  assign unused_ldr = ^{ldr_session, ldr_req, ldr_we, ldr_addr, ldr_wdata, session_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      owner_q       <= OWN_NONE;
      session_q     <= 1'b0;
      core_hold_q   <= 1'b0;
      fetch_flush_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      session_q     <= session_d;
      core_hold_q   <= core_hold_d;
      fetch_flush_q <= fetch_flush_d;
    end
  end

  assign core_hold    = core_hold_q;
  assign fetch_flush  = fetch_flush_q;
  assign fetch_rvalid = (owner_q == OWN_FETCH);
  assign lsu_rvalid   = (owner_q == OWN_LSU);
  assign ldr_rvalid   = (owner_q == OWN_LDR);
  // mem_rdata is already the TCM's output register; only forward it to an owner.
  assign rdata        = (owner_q != OWN_NONE) ? mem_rdata : '0;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
module tb_tcm_port_arbiter;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;
`ifdef TCM_ARB_LOADER_EN
  localparam bit LDR_EN = 1'b1;
`else
  localparam bit LDR_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_LOAD = 2, M_REL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          fetch_req, lsu_req, ldr_req, lsu_we, ldr_we, ldr_session;
  logic [AW-1:0] fetch_addr, lsu_addr, ldr_addr;
  logic [DW-1:0] lsu_wdata, ldr_wdata;
  logic          fetch_gnt, lsu_gnt, ldr_gnt;
  logic          fetch_rvalid, lsu_rvalid, ldr_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          fetch_stall, core_hold, fetch_flush;

  tcm_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .lsu_req(lsu_req), .ldr_req(ldr_req),
    .lsu_we(lsu_we), .ldr_we(ldr_we),
    .fetch_addr(fetch_addr), .lsu_addr(lsu_addr), .ldr_addr(ldr_addr),
    .lsu_wdata(lsu_wdata), .ldr_wdata(ldr_wdata),
    .ldr_session(ldr_session),
    .fetch_gnt(fetch_gnt), .lsu_gnt(lsu_gnt), .ldr_gnt(ldr_gnt),
    .fetch_rvalid(fetch_rvalid), .lsu_rvalid(lsu_rvalid), .ldr_rvalid(ldr_rvalid),
    .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .core_hold(core_hold), .fetch_flush(fetch_flush)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h0000_0013 ^ (DW'(i ^ 4) << 12);
  endfunction

  // Behavioural TCM: synchronous read, registered output.
  logic [DW-1:0] tcm [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tcm[i] <= init_word(i);
      mem_rdata <= '0;
    end else begin
      mem_rdata <= tcm[mem_addr[5:2]];
      if (mem_we) tcm[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            cyc;
    int            owner;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  // Reference model state (spec-level view).
  int            m_mode   = M_RUN;
  int            m_denied = 0;
  bit            m_prev   = 1'b0;
  logic [DW-1:0] ref_mem [16];
  bit            e_fg, e_lg, e_dg;

  // Staged stimulus, applied at the falling edge.
  bit            s_rst, s_fetch_req, s_lsu_req, s_ldr_req, s_lsu_we, s_ldr_we, s_ldr_session;
  logic [AW-1:0] s_fetch_addr, s_lsu_addr, s_ldr_addr;
  logic [DW-1:0] s_lsu_wdata, s_ldr_wdata;
  bit            started = 1'b0;

  task automatic eval();
    bit            fg = 0, lg = 0, dg = 0, we = 0, rd = 0;
    int            own = 0;
    logic [AW-1:0] a  = '0;
    logic [DW-1:0] wd = '0;
    rsp_t          r;
    if (!rst) begin
      if (m_mode == M_RUN) begin
        if (fetch_req && (!lsu_req || m_denied >= int'(LIM))) fg = 1;
        else if (lsu_req) lg = 1;
      end else if (m_mode == M_LOAD) begin
        dg = ldr_req;
      end
    end
    if (fg) begin a = fetch_addr; rd = 1; own = 1; end
    if (lg) begin a = lsu_addr; we = lsu_we; rd = !lsu_we; own = 2; if (lsu_we) wd = lsu_wdata; end
    if (dg) begin a = ldr_addr; we = ldr_we; rd = !ldr_we; own = 3; if (ldr_we) wd = ldr_wdata; end
    chk("fetch_gnt", fetch_gnt, fg);
    chk("lsu_gnt", lsu_gnt, lg);
    chk("ldr_gnt", ldr_gnt, dg);
    chk("fetch_stall", fetch_stall, fetch_req && !fg);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, a);
    if (we || !(fg || lg || dg)) chk("mem_wdata", mem_wdata, wd);
    chk("core_hold", core_hold, m_mode != M_RUN);
    chk("fetch_flush", fetch_flush, m_mode == M_REL);
    if (rd) begin
      r.cyc = cyc + 1; r.owner = own; r.data = ref_mem[a[5:2]];
      sb.push_back(r);
    end
    if (we) ref_mem[a[5:2]] = wd;
    e_fg = fg; e_lg = lg; e_dg = dg;
    if (rst) begin
      m_mode = M_RUN; m_denied = 0; m_prev = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end else begin
      if (fg || m_mode == M_REL) m_denied = 0;
      else if (fetch_req && m_denied < int'(LIM)) m_denied++;
      if (LDR_EN) begin
        case (m_mode)
          M_RUN:   if (ldr_session && !m_prev) m_mode = M_DRAIN;
          M_DRAIN: m_mode = M_LOAD;
          M_LOAD:  if (!ldr_session) m_mode = M_REL;
          default: m_mode = M_RUN;
        endcase
      end
      m_prev = ldr_session;
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = s_rst; fetch_req = s_fetch_req; lsu_req = s_lsu_req; ldr_req = s_ldr_req;
    lsu_we = s_lsu_we; ldr_we = s_ldr_we; ldr_session = s_ldr_session;
    fetch_addr = s_fetch_addr; lsu_addr = s_lsu_addr; ldr_addr = s_ldr_addr;
    lsu_wdata = s_lsu_wdata; ldr_wdata = s_ldr_wdata;
    #1;
    eval();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-3:0] w;
    w = (AW-2)'($urandom());
    return {w, 2'b00};
  endfunction

  // Monitor: pops the scoreboard whenever a response is due or presented.
  initial begin
    rsp_t e;
    bit   due;
    wait (started);
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("rsp_missed", 64'(e.cyc), 64'(cyc));
      end
      due = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (due) begin
        e = sb.pop_front();
        chk("rvalid_vec", {fetch_rvalid, lsu_rvalid, ldr_rvalid},
            {e.owner == 1, e.owner == 2, e.owner == 3});
        chk("rdata", rdata, e.data);
      end else begin
        chk("rvalid_idle", {fetch_rvalid, lsu_rvalid, ldr_rvalid}, 3'b000);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int flushes;
    rst = 1; fetch_req = 0; lsu_req = 0; ldr_req = 0; lsu_we = 0; ldr_we = 0; ldr_session = 0;
    fetch_addr = '0; lsu_addr = '0; ldr_addr = '0; lsu_wdata = '0; ldr_wdata = '0;
    s_rst = 1; s_fetch_req = 0; s_lsu_req = 0; s_ldr_req = 0; s_lsu_we = 0; s_ldr_we = 0;
    s_ldr_session = 0; s_fetch_addr = '0; s_lsu_addr = '0; s_ldr_addr = '0;
    s_lsu_wdata = '0; s_ldr_wdata = '0;

    step();
    chk("rst_rdata", rdata, '0);
    chk("rst_rvalid", {fetch_rvalid, lsu_rvalid, ldr_rvalid}, 3'b000);
    started = 1'b1;
    step();

    // Steady fetch stream from 0x010.
    s_rst = 0; s_fetch_req = 1; s_fetch_addr = 12'h010;
    repeat (6) step();

    // LSU write while fetch is requesting.
    s_lsu_req = 1; s_lsu_we = 1; s_lsu_addr = 12'h020; s_lsu_wdata = 32'hDEAD_BEEF;
    step();
    s_lsu_req = 0; s_lsu_we = 0;
    step();

    // LSU held continuously: fetch must win on the 5th cycle.
    s_lsu_req = 1; s_lsu_addr = 12'h020; first = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (e_fg && first < 0) first = i;
    end
    chk("starve_first_fetch", 64'(first), 64'(LIM + 1));
    s_lsu_req = 0;
    step();

    // Session starting while a fetch read is in flight, three loader writes.
    s_ldr_session = 1;
    step();
    step();
    s_ldr_req = 1; s_ldr_we = 1;
    for (int i = 0; i < 3; i++) begin
      s_ldr_addr = 12'h030 + AW'(4 * i); s_ldr_wdata = 32'hC0DE_0000 + DW'(i);
      step();
    end
    s_ldr_req = 0; s_ldr_we = 0; s_ldr_session = 0;
    step();
    flushes = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fetch_flush === 1'b1) flushes++;
    end
    chk("flush_pulses", 64'(flushes), LDR_EN ? 64'd1 : 64'd0);

    // Reset in the middle of LOAD.
    s_ldr_session = 1; s_ldr_req = 1;
    repeat (3) step();
    s_rst = 1;
    step();
    s_rst = 0; s_ldr_session = 0; s_ldr_req = 0;
    step();
    chk("post_rst_hold", core_hold, 1'b0);
    chk("post_rst_flush", fetch_flush, 1'b0);
    repeat (5) step();

    // Random traffic with requests held until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!s_fetch_req) begin
        s_fetch_req = ($urandom_range(0, 3) != 0); s_fetch_addr = rand_addr();
      end
      if (!s_lsu_req) begin
        s_lsu_req = ($urandom_range(0, 2) != 0); s_lsu_we = 1'($urandom());
        s_lsu_addr = rand_addr(); s_lsu_wdata = $urandom();
      end
      if (!s_ldr_req) begin
        s_ldr_req = 1'($urandom()); s_ldr_we = 1'($urandom());
        s_ldr_addr = rand_addr(); s_ldr_wdata = $urandom();
      end
      if (s_ldr_session) s_ldr_session = ($urandom_range(0, 19) != 0);
      else s_ldr_session = ($urandom_range(0, 29) == 0);
      s_rst = ($urandom_range(0, 299) == 0);
      step();
      if (e_fg) s_fetch_req = 0;
      if (e_lg) s_lsu_req = 0;
      if (e_dg) s_ldr_req = 0;
    end

    s_fetch_req = 0; s_lsu_req = 0; s_ldr_req = 0; s_ldr_session = 0; s_rst = 0;
    repeat (8) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Arbitrates the single read/write port of the instruction TCM between three requesters: instruction fetch, the load/store unit (self-modifying-code stores and loads in the 0x5000 window), and an external program loader. Sits between the IF-stage fetch path, the MEMPREP/MEMEX data path and the ITCM. It grants one access per cycle, returns read data one cycle later to the correct owner, and prevents fetch starvation. It also sequences exclusive loader sessions that hold the core pipeline and flush fetch on release.

## Interface
- ADDR_WIDTH, 12: TCM byte-address width.
- DATA_WIDTH, 32: data word width.
- STARVE_LIMIT, 4: consecutive denied fetch cycles before fetch is forced to highest priority; legal range 1..15.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- fetch_req / lsu_req / ldr_req  in  1 each  access request, held until granted.
- lsu_we / ldr_we  in  1 each  write request (fetch is read-only).
- fetch_addr / lsu_addr / ldr_addr  in  ADDR_WIDTH each  word-aligned address.
- lsu_wdata / ldr_wdata  in  DATA_WIDTH each  write data.
- ldr_session  in  1  loader requests an exclusive session while high.
- fetch_gnt / lsu_gnt / ldr_gnt  out  1 each  request accepted this cycle.
- fetch_rvalid / lsu_rvalid / ldr_rvalid  out  1 each  rdata valid for that owner.
- rdata  out  DATA_WIDTH  registered read data, shared by all owners.
- mem_we  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH  TCM port drive.
- mem_rdata  in  DATA_WIDTH  TCM read data, valid the cycle after the address.
- fetch_stall  out  1  fetch_req & ~fetch_gnt, combinational.
- core_hold  out  1  pipeline must freeze, registered.
- fetch_flush  out  1  one-cycle pulse: discard the fetched instruction and refetch.

## Operation
- Each cycle at most one gnt is high. A granted request drives mem_* combinationally in the same cycle.
- Priority in RUN state: LSU > fetch. The loader is served only in LOAD.
- Starvation: starve_cnt increments each cycle fetch_req is high and not granted, and clears on fetch_gnt. At starve_cnt == STARVE_LIMIT, fetch beats LSU for that cycle. The counter saturates and cannot wrap.
- Read ownership: on a granted read, owner_q records the requester. The next cycle asserts that owner's rvalid with rdata = mem_rdata. Granted writes set owner_q = NONE, so no rvalid follows.
- FSM states and transitions:
  - RUN → DRAIN when ldr_session rises.
  - DRAIN: core_hold = 1, no new grants. Lasts one cycle so an outstanding rvalid completes. → LOAD.
  - LOAD: core_hold = 1; only ldr_req is granted, one per cycle. → RELEASE when ldr_session falls.
  - RELEASE: core_hold = 1, fetch_flush = 1 for one cycle, starve_cnt cleared. → RUN.
- If lsu_req and fetch_req are pending on the DRAIN entry cycle, neither is granted. Both stay pending through the session.
- If ldr_session drops during DRAIN, the FSM still passes through LOAD and RELEASE, spending one cycle in LOAD.

## Timing
- Grant latency: 0 cycles (combinational gnt). Read data latency: 1 cycle after gnt.
- Back-to-back grants to different owners are legal every cycle.
- Reset values:
  - all gnt, rvalid, core_hold, fetch_flush = 0.
  - rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - FSM = RUN, starve_cnt = 0, owner_q = NONE.
- rst asserted mid-session returns to RUN next cycle with core_hold = 0. Any pending rvalid is dropped and no fetch_flush is issued.
- A session is entered 2 cycles after the ldr_session rise: one cycle to register it, one cycle in DRAIN. The first ldr_gnt is possible on the cycle LOAD is entered.

## Configuration
- TCM_ARB_LOADER_EN:
  - Defined: loader ports and DRAIN/LOAD/RELEASE states are present as described.
  - Undefined: the FSM is fixed in RUN, and ldr_session/ldr_req are ignored. ldr_gnt, ldr_rvalid, core_hold and fetch_flush are tied to 0.

## Structure
- Package tcm_arb_pkg holds:
  - owner_e: OWN_NONE, OWN_FETCH, OWN_LSU, OWN_LDR.
  - arb_state_e: RUN, DRAIN, LOAD, RELEASE.
  - STARVE_LIMIT default constant.
- Sub-module tcm_arb_starve_counter: saturating counter with clear, increment and at-limit output.

## Test plan
- Reset, then fetch_req every cycle with addr 0x010 and mem_rdata = 0x00000013 → fetch_gnt every cycle, fetch_rvalid one cycle later, rdata = 0x00000013.
- lsu_req write to 0x020 with data 0xDEADBEEF while fetch_req is high → lsu_gnt, mem_we = 1, fetch_stall = 1, no lsu_rvalid; fetch is granted the next cycle.
- lsu_req held high continuously with fetch_req high, STARVE_LIMIT = 4 → fetch_gnt on the 5th cycle, then LSU regains priority.
- ldr_session rises while a fetch read is in flight → that fetch_rvalid still fires, then DRAIN, then LOAD with core_hold = 1. Three loader writes are granted on consecutive cycles. On release, fetch_flush pulses for exactly 1 cycle and core_hold drops the next cycle.
- rst asserted during LOAD → next cycle all outputs are at reset values and the FSM is in RUN.
- Build without TCM_ARB_LOADER_EN and assert ldr_session/ldr_req → core_hold, ldr_gnt and fetch_flush stay 0; fetch and LSU traffic is unaffected.
